// File: rtl/hilo_muldiv_seq_if.sv
// Request/commit bundle between control unit, multiply/divide sequencer and HI/LO register file.
interface hilo_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             flush;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             rf_reg_write;
  logic [2:0]       rf_hilo_type;
  logic [WIDTH-1:0] rf_lo;
  logic [WIDTH-1:0] rf_hi;

  modport master (
    output start, op, flush, src_a, src_b,
    input  busy, done, div_by_zero, rf_reg_write, rf_hilo_type, rf_lo, rf_hi
  );

  modport slave (
    input  start, op, flush, src_a, src_b,
    output busy, done, div_by_zero, rf_reg_write, rf_hilo_type, rf_lo, rf_hi
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Bit-serial MULT/MULTU/DIV/DIVU sequencer committing one combined HI/LO write.
// Write lands WIDTH+2 edges after start is sampled; start while busy is dropped, never queued.
module hilo_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic              clk,
  input logic              reset,
  hilo_muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, sign_a_q, sign_b_q, dbz_q;
  logic [WIDTH-1:0]   mag_b_q, orig_a_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               busy_q, done_q, dbz_out_q, wr_q;
  logic [2:0]         type_q;
  logic [WIDTH-1:0]   lo_q, hi_q;

  logic               op_signed;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in, acc_hi, acc_lo;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;

  assign op_signed = ~bus.op[0];
  assign mag_a_in  = (op_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b_in  = (op_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
  assign acc_hi    = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo    = acc_q[WIDTH-1:0];

  // Multiply keeps the multiplier in acc_lo; divide keeps remainder:dividend/quotient in hi:lo.
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, mag_b_q};
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, mag_b_q};
  assign div_sub   = div_trial[WIDTH-1:0] - mag_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIXUP;
      S_FIXUP: state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_q    <= 1'b0;
      mag_b_q  <= '0;
      orig_a_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          cnt_q    <= '0;
          is_div_q <= bus.op[1];
          sign_a_q <= op_signed & bus.src_a[WIDTH-1];
          sign_b_q <= op_signed & bus.src_b[WIDTH-1];
          mag_b_q  <= mag_b_in;
          orig_a_q <= bus.src_a;
          acc_q    <= {{WIDTH{1'b0}}, mag_a_in};
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q)
            acc_q <= {div_ge ? div_sub : div_trial[WIDTH-1:0], acc_lo[WIDTH-2:0], div_ge};
          else if (acc_lo[0])
            acc_q <= {mul_sum, acc_lo[WIDTH-1:1]};
          else
            acc_q <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
        S_FIXUP: begin
          dbz_q <= 1'b0;
          if (is_div_q && mag_b_q == '0) begin
            acc_q <= {orig_a_q, {WIDTH{1'b1}}};
            dbz_q <= 1'b1;
          end else if (is_div_q) begin
            // Remainder follows the dividend; quotient follows the sign product.
            acc_q <= {sign_a_q ? -acc_hi : acc_hi, (sign_a_q ^ sign_b_q) ? -acc_lo : acc_lo};
          end else if (sign_a_q ^ sign_b_q) begin
            acc_q <= -acc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      wr_q      <= 1'b0;
      type_q    <= 3'b000;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_q == S_WRITE);
      wr_q      <= (state_q == S_WRITE);
      dbz_out_q <= (state_q == S_WRITE) && dbz_q;
      type_q    <= (state_q == S_WRITE) ? 3'b011 : 3'b000;
      if (state_q == S_WRITE) begin
        lo_q <= acc_lo;
        hi_q <= acc_hi;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.div_by_zero  = dbz_out_q;
  assign bus.rf_reg_write = wr_q;
  assign bus.rf_hilo_type = type_q;
  assign bus.rf_lo        = lo_q;
  assign bus.rf_hi        = hi_q;
endmodule
